// File: rtl/button_event_gen_if.sv
// button_event_gen_if: front-panel switch level in, event pulses/levels out.
// master drives the switch level, slave is the event generator.
interface button_event_gen_if;
  logic i_switch;
  logic o_press;
  logic o_release;
  logic o_held;
  logic o_long_pulse;
  logic o_long;
  logic o_repeat;

  modport master (
    output i_switch,
    input  o_press,
    input  o_release,
    input  o_held,
    input  o_long_pulse,
    input  o_long,
    input  o_repeat
  );

  modport slave (
    input  i_switch,
    output o_press,
    output o_release,
    output o_held,
    output o_long_pulse,
    output o_long,
    output o_repeat
  );
endinterface

// File: rtl/button_event_gen.sv
// button_event_gen: debounced level -> press/release/long/repeat events.
// Auto-repeat is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_event_gen #(
  parameter int LONG_PRESS_LIMIT = 12500000,
  parameter int REPEAT_PERIOD    = 2500000,
  parameter int CNT_WIDTH        = 24
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  button_event_gen_if.slave   btn
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_LONG  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_TC =
    CNT_WIDTH'(LONG_PRESS_LIMIT - 1);

  // Reject parameter sets the counter cannot represent.
  if (LONG_PRESS_LIMIT < 2) begin : g_bad_limit
    $error("LONG_PRESS_LIMIT must be >= 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_period
    $error("REPEAT_PERIOD must be >= 2");
  end
  if (CNT_WIDTH < 31) begin : g_width_chk
    if ((LONG_PRESS_LIMIT - 1) >= (1 << CNT_WIDTH) ||
        (REPEAT_PERIOD - 1) >= (1 << CNT_WIDTH)) begin : g_bad_width
      $error("CNT_WIDTH too narrow");
    end
  end

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 prev_q;
  logic                 press_q, press_d;
  logic                 rel_q, rel_d;
  logic                 held_q;
  logic                 lp_q, lp_d;
  logic                 long_q;
  logic                 sw;

  assign sw = btn.i_switch;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REP_TC =
    CNT_WIDTH'(REPEAT_PERIOD - 1);

  logic rep_q, rep_d;
`endif

  // Next state, counter and pulse decode; release beats any terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    lp_d    = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rep_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (sw && !prev_q) begin
          state_d = S_PRESS;
          press_d = 1'b1;
        end
      end
      S_PRESS: begin
        unique case (1'b1)
          !sw: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rel_d   = prev_q;
          end
          (sw && cnt_q == LONG_TC): begin
            state_d = S_LONG;
            cnt_d   = '0;
            lp_d    = 1'b1;
          end
          default: begin
            cnt_d = cnt_q + 1'b1;
          end
        endcase
      end
      S_LONG: begin
`ifdef BUTTON_AUTO_REPEAT_EN
        unique case (1'b1)
          !sw: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rel_d   = prev_q;
          end
          (sw && cnt_q == REP_TC): begin
            cnt_d = '0;
            rep_d = 1'b1;
          end
          default: begin
            cnt_d = cnt_q + 1'b1;
          end
        endcase
`else
        cnt_d = '0;
        if (!sw) begin
          state_d = S_IDLE;
          rel_d   = prev_q;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, edge history and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      held_q  <= 1'b0;
      lp_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= sw;
      press_q <= press_d;
      rel_q   <= rel_d;
      held_q  <= (state_d != S_IDLE);
      lp_q    <= lp_d;
      long_q  <= (state_d == S_LONG);
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  // Auto-repeat pulse register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rep_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
    end
  end

  assign btn.o_repeat = rep_q;
`else
  assign btn.o_repeat = 1'b0;
`endif

  assign btn.o_press      = press_q;
  assign btn.o_release    = rel_q;
  assign btn.o_held       = held_q;
  assign btn.o_long_pulse = lp_q;
  assign btn.o_long       = long_q;

endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: random hold/release traffic against a run-length model.
// Expected events are derived from the length of the current high run.
module tb_button_event_gen;

  localparam int LIMIT  = 8;
  localparam int PERIOD = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic i_clk;
  logic i_rst_n;

  button_event_gen_if btn ();

  button_event_gen #(
    .LONG_PRESS_LIMIT (LIMIT),
    .REPEAT_PERIOD    (PERIOD),
    .CNT_WIDTH        (5)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .btn     (btn)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int run      = 0;
  bit prev_v   = 1'b0;

  function automatic logic [5:0] obs();
    return {btn.o_press, btn.o_release, btn.o_held,
            btn.o_long_pulse, btn.o_long, btn.o_repeat};
  endfunction

  task automatic check(input string tag,
                       input logic [5:0] got,
                       input logic [5:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)",
                  tag, got, exp, $time);
  endtask

  // One clock with switch level v; model works from the high-run length.
  task automatic step(input string tag, input bit v);
    int age;
    logic [5:0] e;
    btn.i_switch = v;
    @(posedge i_clk);
    #1;
    run = v ? run + 1 : 0;
    age = run - 1;
    e[5] = v && run == 1;
    e[4] = !v && prev_v;
    e[3] = v;
    e[2] = v && age == LIMIT;
    e[1] = v && age >= LIMIT;
    e[0] = REP_EN && v && age > LIMIT &&
           ((age - LIMIT) % PERIOD) == 0;
    prev_v = v;
    check(tag, obs(), e);
    @(negedge i_clk);
  endtask

  task automatic hold(input string tag, input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(tag, 1'b1);
    for (int i = 0; i < lo; i++) step(tag, 1'b0);
  endtask

  // Reset the DUT and the model; outputs must read 0 throughout.
  task automatic do_reset(input string tag, input bit sw);
    btn.i_switch = sw;
    i_rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge i_clk);
      #1;
      check(tag, obs(), 6'b0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run = 0;
    prev_v = 1'b0;
  endtask

  initial begin
    btn.i_switch = 1'b1;
    i_rst_n = 1'b0;
    #1;
    check("reset_async", obs(), 6'b0);
    do_reset("reset_hold", 1'b1);
    hold("reset_press", 3, 3);

    hold("short", 5, 3);
    hold("long", 20, 3);
    hold("tc_release", 8, 3);
    hold("glitch", 1, 2);
    hold("repeat_edge", 12, 2);
    hold("exact_long", 9, 2);

    for (int i = 0; i < 10; i++) step("mid_hold", 1'b1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("async_drop", obs(), 6'b0);
    @(negedge i_clk);
    do_reset("mid_rst", 1'b0);
    hold("no_release", 0, 3);

    for (int i = 0; i < 10; i++) step("mid_hold2", 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_drop2", obs(), 6'b0);
    @(negedge i_clk);
    do_reset("mid_rst2", 1'b1);
    hold("fresh_press", 4, 2);

    for (int s = 0; s < 40; s++) begin
      hold("random", $urandom_range(1, 30), $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
